// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate scheduler.
package parking_pkg;

    typedef enum logic {
        G_IDLE = 1'b0,
        G_OPEN = 1'b1
    } gate_state_t;

    localparam int unsigned MAX_GATES = 8;

    // Encoding of gate_is_exit.
    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

endpackage

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// Round-robin arbiter: scan starts at the pointer, pointer moves past the winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] sel;
    int unsigned   idx;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        grant   = '0;
        valid   = 1'b0;
        win_idx = '0;
        sel     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = idx[PW-1:0];
            if (!valid && req[sel]) begin
                grant[sel] = 1'b1;
                valid      = 1'b1;
                win_idx    = sel;
            end
        end
        ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    end

    // Pointer register, moves only when a decision is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && valid) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Multiplexes gate entry/exit requests onto the single-event occupancy board.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int unsigned NUM_GATES   = 4,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] gate_req,
    input  logic [NUM_GATES-1:0] gate_is_exit,
    input  logic [NUM_GATES-1:0] gate_is_uni,
    input  logic                 uni_is_vacated_space,
    input  logic                 is_vacated_space,
    output logic                 car_entered,
    output logic                 is_uni_car_entered,
    output logic                 car_exited,
    output logic                 is_uni_car_exited,
    output logic [NUM_GATES-1:0] gate_ack,
    output logic [NUM_GATES-1:0] gate_nack,
    output logic [NUM_GATES-1:0] barrier_open,
    output logic [CNT_W-1:0]     entries_granted,
    output logic [CNT_W-1:0]     entries_rejected
);

    localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES);

    gate_state_t            state_q [NUM_GATES];
    gate_state_t            state_d [NUM_GATES];
    logic [7:0]             cnt_q   [NUM_GATES];
    logic [7:0]             cnt_d   [NUM_GATES];

    logic [NUM_GATES-1:0]   entry_req, exit_req, entry_grant, exit_grant;
    logic                   entry_valid, exit_valid, entry_uni, entry_allowed;
    logic                   entry_ok, entry_rej, exit_uni;
    logic [NUM_GATES-1:0]   ack_d;

    logic                   ce_q, ceu_q, cx_q, cxu_q;
    logic [NUM_GATES-1:0]   ack_q, nack_q;
    logic [CNT_W-1:0]       granted_q, rejected_q;

    // Candidate sets; a gate being nacked this cycle is masked so a lingering
    // request is not rejected twice. Entries pause while the board settles.
    always_comb begin
        entry_req = '0;
        exit_req  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            if (gate_req[g] && state_q[g] == G_IDLE && !nack_q[g]) begin
                entry_req[g] = (gate_is_exit[g] == DIR_ENTRY) && !ce_q;
                exit_req[g]  = (gate_is_exit[g] == DIR_EXIT);
            end
        end
    end

    rr_arbiter #(.N(NUM_GATES)) u_entry_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (entry_req),
        .advance (1'b1),
        .grant   (entry_grant),
        .valid   (entry_valid)
    );

    rr_arbiter #(.N(NUM_GATES)) u_exit_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (exit_req),
        .advance (1'b1),
        .grant   (exit_grant),
        .valid   (exit_valid)
    );

    // Vacancy decision; university cars may fall back to public spaces.
    always_comb begin
        entry_uni     = |(entry_grant & gate_is_uni);
        exit_uni      = |(exit_grant & gate_is_uni);
        entry_allowed = entry_uni ? (uni_is_vacated_space | is_vacated_space)
                                  : is_vacated_space;
        entry_ok      = entry_valid & entry_allowed;
        entry_rej     = entry_valid & ~entry_allowed;
        ack_d         = (entry_ok ? entry_grant : '0) | (exit_valid ? exit_grant : '0);
    end

    // Per-gate barrier FSM next state.
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            state_d[g] = state_q[g];
            cnt_d[g]   = cnt_q[g];
            unique case (state_q[g])
                G_IDLE: begin
                    if (ack_d[g]) begin
                        state_d[g] = G_OPEN;
                        cnt_d[g]   = OPEN_LOAD;
                    end
                end
                G_OPEN: begin
                    if (cnt_q[g] == 8'd1) begin
                        state_d[g] = G_IDLE;
                        cnt_d[g]   = 8'd0;
                    end else begin
                        cnt_d[g] = cnt_q[g] - 8'd1;
                    end
                end
                default: begin
                    state_d[g] = G_IDLE;
                    cnt_d[g]   = 8'd0;
                end
            endcase
        end
    end

    // Gate FSM state registers.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_GATES; g++) begin
            if (reset) begin
                state_q[g] <= G_IDLE;
                cnt_q[g]   <= 8'd0;
            end else begin
                state_q[g] <= state_d[g];
                cnt_q[g]   <= cnt_d[g];
            end
        end
    end

    // Registered handshake pulses, board pulses and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= '0;
            nack_q     <= '0;
            ce_q       <= 1'b0;
            ceu_q      <= 1'b0;
            cx_q       <= 1'b0;
            cxu_q      <= 1'b0;
            granted_q  <= '0;
            rejected_q <= '0;
        end else begin
            ack_q  <= ack_d;
            nack_q <= entry_rej ? entry_grant : '0;
            ce_q   <= entry_ok;
            ceu_q  <= entry_ok & entry_uni;
            cx_q   <= exit_valid;
            cxu_q  <= exit_valid & exit_uni;
            if (entry_ok && granted_q != '1) begin
                granted_q <= granted_q + CNT_W'(1);
            end
            if (entry_rej && rejected_q != '1) begin
                rejected_q <= rejected_q + CNT_W'(1);
            end
        end
    end

    // Output drive.
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            barrier_open[g] = (state_q[g] == G_OPEN);
        end
        gate_ack           = ack_q;
        gate_nack          = nack_q;
        car_entered        = ce_q;
        is_uni_car_entered = ceu_q;
        car_exited         = cx_q;
        is_uni_car_exited  = cxu_q;
        entries_granted    = granted_q;
        entries_rejected   = rejected_q;
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed plus randomized bench for parking_gate_scheduler with a cycle-level reference model.
module tb_parking_gate_scheduler;

    localparam int NG = 4;
    localparam int OC = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NG-1:0] gate_req = '0;
    logic [NG-1:0] gate_is_exit = '0;
    logic [NG-1:0] gate_is_uni = '0;
    logic          uni_vac = 1'b0;
    logic          vac = 1'b0;

    logic          car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [NG-1:0] gate_ack, gate_nack, barrier_open;
    logic [CW-1:0] entries_granted, entries_rejected;

    parking_gate_scheduler #(
        .NUM_GATES   (NG),
        .OPEN_CYCLES (OC),
        .CNT_W       (CW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .gate_req             (gate_req),
        .gate_is_exit         (gate_is_exit),
        .gate_is_uni          (gate_is_uni),
        .uni_is_vacated_space (uni_vac),
        .is_vacated_space     (vac),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .gate_ack             (gate_ack),
        .gate_nack            (gate_nack),
        .barrier_open         (barrier_open),
        .entries_granted      (entries_granted),
        .entries_rejected     (entries_rejected)
    );

    always #5 clk = ~clk;

    // Reference model: remaining open cycles per gate (0 = closed), RR pointers,
    // expected registered outputs and statistics as plain integers.
    int            open_left [NG];
    int            ptr_en, ptr_ex;
    logic [NG-1:0] e_ack, e_nack;
    logic          e_ce, e_ceu, e_cx, e_cxu;
    int            e_gr, e_rj;
    int            n_checks = 0;
    int            n_fail = 0;

    function automatic int pick(input int ptr, input logic [NG-1:0] cand);
        for (int k = 0; k < NG; k++) begin
            if (cand[(ptr + k) % NG]) return (ptr + k) % NG;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [NG-1:0] en_c, ex_c;
        int we, wx;
        bit allow, idle;
        if (reset) begin
            for (int g = 0; g < NG; g++) open_left[g] = 0;
            ptr_en = 0; ptr_ex = 0;
            e_ack = '0; e_nack = '0;
            e_ce = 0; e_ceu = 0; e_cx = 0; e_cxu = 0;
            e_gr = 0; e_rj = 0;
            return;
        end
        for (int g = 0; g < NG; g++) begin
            idle    = (open_left[g] == 0) && gate_req[g] && !e_nack[g];
            en_c[g] = idle && !gate_is_exit[g] && !e_ce;
            ex_c[g] = idle && gate_is_exit[g];
        end
        we = pick(ptr_en, en_c);
        wx = pick(ptr_ex, ex_c);
        for (int g = 0; g < NG; g++) if (open_left[g] > 0) open_left[g]--;
        e_ack = '0; e_nack = '0;
        e_ce = 0; e_ceu = 0; e_cx = 0; e_cxu = 0;
        if (we >= 0) begin
            allow  = gate_is_uni[we] ? (uni_vac || vac) : vac;
            ptr_en = (we + 1) % NG;
            if (allow) begin
                e_ack[we] = 1'b1;
                e_ce = 1; e_ceu = gate_is_uni[we];
                open_left[we] = OC;
                if (e_gr < (1 << CW) - 1) e_gr++;
            end else begin
                e_nack[we] = 1'b1;
                if (e_rj < (1 << CW) - 1) e_rj++;
            end
        end
        if (wx >= 0) begin
            e_ack[wx] = 1'b1;
            e_cx = 1; e_cxu = gate_is_uni[wx];
            open_left[wx] = OC;
            ptr_ex = (wx + 1) % NG;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [NG-1:0] e_bar;
        for (int g = 0; g < NG; g++) e_bar[g] = (open_left[g] > 0);
        chk("gate_ack", 32'(gate_ack), 32'(e_ack));
        chk("gate_nack", 32'(gate_nack), 32'(e_nack));
        chk("car_entered", 32'(car_entered), 32'(e_ce));
        chk("is_uni_car_entered", 32'(is_uni_car_entered), 32'(e_ceu));
        chk("car_exited", 32'(car_exited), 32'(e_cx));
        chk("is_uni_car_exited", 32'(is_uni_car_exited), 32'(e_cxu));
        chk("barrier_open", 32'(barrier_open), 32'(e_bar));
        chk("entries_granted", 32'(entries_granted), 32'(e_gr));
        chk("entries_rejected", 32'(entries_rejected), 32'(e_rj));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gate_req = '0;
        step();
        reset = 1'b0;
    endtask

    // One randomized cycle: gates drop requests after nack (and usually after
    // ack), idle gates raise new requests with fresh direction/category.
    task automatic random_cycle(input bit allow_reset);
        for (int g = 0; g < NG; g++) begin
            if (gate_req[g]) begin
                if (e_nack[g] || (e_ack[g] && $urandom_range(0, 9) < 7)) gate_req[g] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                gate_req[g]     = 1'b1;
                gate_is_exit[g] = 1'($urandom_range(0, 1));
                gate_is_uni[g]  = 1'($urandom_range(0, 1));
            end
        end
        vac     = ($urandom_range(0, 9) < 6);
        uni_vac = ($urandom_range(0, 9) < 5);
        reset   = allow_reset && ($urandom_range(0, 99) < 2);
        step();
        reset = 1'b0;
    endtask

    initial begin
        int order [$];

        // Reset state.
        reset = 1'b1;
        step();
        step();
        chk("rst_ack", 32'(gate_ack), 32'h0);
        chk("rst_barrier", 32'(barrier_open), 32'h0);
        reset = 1'b0;

        // Single public entry on gate 2.
        gate_req = 4'b0100; gate_is_exit = '0; gate_is_uni = '0; vac = 1'b1; uni_vac = 1'b0;
        step();
        chk("t1_ack", 32'(gate_ack), 32'b0100);
        chk("t1_ce", 32'(car_entered), 32'h1);
        gate_req = '0;
        step();
        step();
        chk("t1_bar_hi", 32'(barrier_open), 32'b0100);
        step();
        chk("t1_bar_lo", 32'(barrier_open), 32'h0);
        chk("t1_granted", 32'(entries_granted), 32'h1);

        // Three simultaneous entries: served 0, 1, 3 with a settle gap.
        do_reset();
        gate_req = 4'b1011;
        for (int s = 0; s < 10; s++) begin
            step();
            for (int g = 0; g < NG; g++) begin
                if (gate_ack[g]) begin
                    order.push_back(g);
                    gate_req[g] = 1'b0;
                end
            end
        end
        chk("t2_count", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            chk("t2_first", 32'(order[0]), 32'd0);
            chk("t2_second", 32'(order[1]), 32'd1);
            chk("t2_third", 32'(order[2]), 32'd3);
        end

        // University fallback to public, then rejection with no space.
        do_reset();
        gate_req = 4'b0010; gate_is_uni = 4'b0010; uni_vac = 1'b0; vac = 1'b1;
        step();
        chk("t3_ack", 32'(gate_ack), 32'b0010);
        chk("t3_uni", 32'(is_uni_car_entered), 32'h1);
        gate_req = '0;
        repeat (4) step();
        vac = 1'b0;
        gate_req = 4'b0010;
        step();
        chk("t3_nack", 32'(gate_nack), 32'b0010);
        chk("t3_no_ce", 32'(car_entered), 32'h0);
        chk("t3_rejected", 32'(entries_rejected), 32'h1);
        gate_req = '0;
        gate_is_uni = '0;
        step();

        // Entry on gate 0 and exit on gate 3 in the same cycle.
        do_reset();
        gate_req = 4'b1001; gate_is_exit = 4'b1000; vac = 1'b1;
        step();
        chk("t4_ack", 32'(gate_ack), 32'b1001);
        chk("t4_ce", 32'(car_entered), 32'h1);
        chk("t4_cx", 32'(car_exited), 32'h1);
        gate_req = '0; gate_is_exit = '0;
        repeat (3) step();

        // Request held through OPEN: re-served one cycle after the barrier falls.
        do_reset();
        gate_req = 4'b0100; vac = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s == 1 || s == 5) chk("t5_ack", 32'(gate_ack), 32'b0100);
            else chk("t5_no_ack", 32'(gate_ack), 32'h0);
            if (s == 4) chk("t5_bar_lo", 32'(barrier_open), 32'h0);
        end
        gate_req = '0;
        repeat (4) step();

        // Reset while a barrier is open and another gate is requesting.
        do_reset();
        gate_req = 4'b0010; vac = 1'b1;
        step();
        chk("t6_pre_bar", 32'(barrier_open), 32'b0010);
        gate_req = 4'b0001;
        reset = 1'b1;
        step();
        chk("t6_ack", 32'(gate_ack), 32'h0);
        chk("t6_bar", 32'(barrier_open), 32'h0);
        chk("t6_ce", 32'(car_entered), 32'h0);
        reset = 1'b0;
        gate_req = 4'b1001;
        step();
        chk("t6_ptr0", 32'(gate_ack), 32'b0001);
        gate_req = '0;
        repeat (4) step();

        // Randomized traffic; first without resets so the counters saturate.
        do_reset();
        repeat (600) random_cycle(1'b0);
        repeat (400) random_cycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
